// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and state encoding for the convolution row controller.
//   BIT_LEN  - pixel/weight width
//   M_LEN    - kernel dimension (3x3 only)
//   CONV_LEN - width of the datapath sum
//   RES_LAT  - cycles from a row transfer edge to its sum being valid on i_conv_data
//   state_t  - controller FSM encoding
package conv_pkg;

    localparam int BIT_LEN  = 8;
    localparam int M_LEN    = 3;
    localparam int CONV_LEN = 20;
    localparam int RES_LAT  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_K = 3'd1,
        ST_FILL   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

endpackage

// File: rtl/conv_res_fifo.sv
// conv_res_fifo: small synchronous result buffer with occupancy count.
//   i_clk, i_reset          - clock, synchronous active-high reset (empties the buffer)
//   i_wr_en / i_wr_data     - push (ignored when full)
//   i_rd_en                 - pop of the current head (ignored when empty)
//   o_rd_data               - current head, 0 while empty
//   o_empty / o_count       - status; count ranges 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module conv_res_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_wr_en,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_rd_en,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full;
    logic             wr_do;
    logic             rd_do;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign o_empty = (count_reg == '0);
    assign wr_do   = i_wr_en && !full;
    assign rd_do   = i_rd_en && !o_empty;

    // Storage is not reset; emptiness is tracked by the count alone.
    always_ff @(posedge i_clk) begin
        if (wr_do) begin
            mem[wr_ptr_reg] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_do) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd_do) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            count_reg <= count_reg + CNT_W'(wr_do) - CNT_W'(rd_do);
        end
    end

    // Head is presented combinationally; masked so stale storage never leaks out.
    assign o_rd_data = o_empty ? '0 : mem[rd_ptr_reg];
    assign o_count   = count_reg;

endmodule

// File: rtl/conv_ctrl.sv
// conv_ctrl: frame controller for a 3x3 row-streaming convolution datapath.
//   i_clk, i_reset             - clock, synchronous active-high reset
//   i_start, i_rows            - frame start pulse and image row count (sampled in IDLE)
//   o_busy, o_err              - frame in progress; pulse when i_rows < 3 at start
//   i_k_valid/o_k_ready/i_k_data       - kernel row stream (3 rows)
//   i_img_valid/o_img_ready/i_img_data - image row stream (i_rows rows)
//   o_selec_K/o_selec_I, o_data_kernel/o_data_img - row shift enables and data to datapath
//   i_conv_data                - datapath sum, valid RES_LAT cycles after a row transfer
//   o_res_valid/i_res_ready/o_res_data - result stream out of the result buffer
//   o_frame_done               - pulse once the last result of a frame has been consumed
import conv_pkg::*;

module conv_ctrl #(
    parameter int BIT_LEN    = conv_pkg::BIT_LEN,
    parameter int M_LEN      = conv_pkg::M_LEN,
    parameter int CONV_LEN   = conv_pkg::CONV_LEN,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [7:0]               i_rows,
    output logic                     o_busy,
    output logic                     o_err,
    input  logic                     i_k_valid,
    output logic                     o_k_ready,
    input  logic [BIT_LEN*M_LEN-1:0] i_k_data,
    input  logic                     i_img_valid,
    output logic                     o_img_ready,
    input  logic [BIT_LEN*M_LEN-1:0] i_img_data,
    output logic                     o_selec_K,
    output logic                     o_selec_I,
    output logic [BIT_LEN*M_LEN-1:0] o_data_kernel,
    output logic [BIT_LEN*M_LEN-1:0] o_data_img,
    input  logic [CONV_LEN-1:0]      i_conv_data,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic [CONV_LEN-1:0]      o_res_data,
    output logic                     o_frame_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IFL_W = $clog2(RES_LAT + 1);

    state_t             state_reg, state_next;
    logic [7:0]         rows_left_reg, rows_left_next;
    logic [1:0]         k_cnt_reg, k_cnt_next;
    logic [1:0]         fill_cnt_reg, fill_cnt_next;
    logic [RES_LAT-1:0] pipe_reg, pipe_next;
    logic               stream_fire;
    logic [IFL_W-1:0]   in_flight;
    logic [CNT_W:0]     occupancy;
    logic               credit_ok;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;

    // One bit per pipeline stage marks a result-producing row still in the datapath.
    // The last stage lines up with the cycle its sum sits on i_conv_data.
    assign pipe_next[0] = stream_fire;
    for (genvar gi = 1; gi < RES_LAT; gi++) begin : g_pipe
        assign pipe_next[gi] = pipe_reg[gi-1];
    end

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RES_LAT; i++) begin
            in_flight = in_flight + IFL_W'(pipe_reg[i]);
        end
    end

    // Reserve a buffer slot for every row before accepting it, so a result
    // emerging from the datapath always has somewhere to go.
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(in_flight);
    assign credit_ok = (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg     <= ST_IDLE;
            rows_left_reg <= '0;
            k_cnt_reg     <= '0;
            fill_cnt_reg  <= '0;
            pipe_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            rows_left_reg <= rows_left_next;
            k_cnt_reg     <= k_cnt_next;
            fill_cnt_reg  <= fill_cnt_next;
            pipe_reg      <= pipe_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rows_left_next = rows_left_reg;
        k_cnt_next     = k_cnt_reg;
        fill_cnt_next  = fill_cnt_reg;
        stream_fire    = 1'b0;
        o_k_ready      = 1'b0;
        o_img_ready    = 1'b0;
        o_err          = 1'b0;
        o_frame_done   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_rows >= 8'(M_LEN)) begin
                        state_next     = ST_LOAD_K;
                        rows_left_next = i_rows;
                        k_cnt_next     = '0;
                        fill_cnt_next  = '0;
                    end else begin
                        o_err = 1'b1;
                    end
                end
            end
            ST_LOAD_K: begin
                o_k_ready = 1'b1;
                if (i_k_valid) begin
                    if (k_cnt_reg == 2'(M_LEN - 1)) begin
                        state_next = ST_FILL;
                        k_cnt_next = '0;
                    end else begin
                        k_cnt_next = k_cnt_reg + 2'd1;
                    end
                end
            end
            ST_FILL: begin
                // Priming rows complete the first window but produce no result.
                o_img_ready = 1'b1;
                if (i_img_valid) begin
                    rows_left_next = rows_left_reg - 8'd1;
                    if (fill_cnt_reg == 2'(M_LEN - 2)) begin
                        state_next    = ST_STREAM;
                        fill_cnt_next = '0;
                    end else begin
                        fill_cnt_next = fill_cnt_reg + 2'd1;
                    end
                end
            end
            ST_STREAM: begin
                o_img_ready = credit_ok;
                if (i_img_valid && credit_ok) begin
                    stream_fire    = 1'b1;
                    rows_left_next = rows_left_reg - 8'd1;
                    if (rows_left_reg == 8'd1) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((pipe_reg == '0) && fifo_empty) begin
                    o_frame_done = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_busy        = (state_reg != ST_IDLE);
    assign o_selec_K     = o_k_ready && i_k_valid;
    assign o_selec_I     = o_img_ready && i_img_valid;
    assign o_data_kernel = o_selec_K ? i_k_data : '0;
    assign o_data_img    = o_selec_I ? i_img_data : '0;
    assign o_res_valid   = !fifo_empty;

    conv_res_fifo #(
        .WIDTH (CONV_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (pipe_reg[RES_LAT-1]),
        .i_wr_data (i_conv_data),
        .i_rd_en   (i_res_ready),
        .o_rd_data (o_res_data),
        .o_empty   (fifo_empty),
        .o_count   (fifo_count)
    );

endmodule

// File: tb/tb_conv_ctrl.sv
`timescale 1ns/1ps
module tb_conv_ctrl;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [7:0]  i_rows;
    logic        o_busy, o_err;
    logic        i_k_valid, o_k_ready;
    logic [23:0] i_k_data;
    logic        i_img_valid, o_img_ready;
    logic [23:0] i_img_data;
    logic        o_selec_K, o_selec_I;
    logic [23:0] o_data_kernel, o_data_img;
    logic [19:0] i_conv_data;
    logic        o_res_valid, i_res_ready;
    logic [19:0] o_res_data;
    logic        o_frame_done;

    always #5 clk = ~clk;

    conv_ctrl #(
        .BIT_LEN(8), .M_LEN(3), .CONV_LEN(20), .FIFO_DEPTH(4)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_rows(i_rows),
        .o_busy(o_busy), .o_err(o_err),
        .i_k_valid(i_k_valid), .o_k_ready(o_k_ready), .i_k_data(i_k_data),
        .i_img_valid(i_img_valid), .o_img_ready(o_img_ready), .i_img_data(i_img_data),
        .o_selec_K(o_selec_K), .o_selec_I(o_selec_I),
        .o_data_kernel(o_data_kernel), .o_data_img(o_data_img),
        .i_conv_data(i_conv_data),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data),
        .o_frame_done(o_frame_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] conv9(input logic [23:0] k0, k1, k2, x0, x1, x2);
        logic [23:0] k [3];
        logic [23:0] x [3];
        int s;
        k[0] = k0; k[1] = k1; k[2] = k2;
        x[0] = x0; x[1] = x1; x[2] = x2;
        s = 0;
        for (int j = 0; j < 3; j++)
            for (int p = 0; p < 3; p++)
                s += int'(k[j][8*p +: 8]) * int'(x[j][8*p +: 8]);
        return 20'(s);
    endfunction

    // Behavioural datapath: row shift registers then a registered multiply-add.
    logic [23:0] dk [3];
    logic [23:0] di [3];
    logic [19:0] mult;
    always @(posedge clk) begin
        if (i_reset) begin
            for (int j = 0; j < 3; j++) begin dk[j] <= '0; di[j] <= '0; end
            mult <= '0;
        end else begin
            if (o_selec_K) begin dk[0] <= dk[1]; dk[1] <= dk[2]; dk[2] <= o_data_kernel; end
            if (o_selec_I) begin di[0] <= di[1]; di[1] <= di[2]; di[2] <= o_data_img; end
            mult <= conv9(dk[0], dk[1], dk[2], di[0], di[1], di[2]);
        end
    end
    assign i_conv_data = mult;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor
    logic [19:0] got_q [$];
    int k_xfer, i_xfer, selk_cnt, seli_cnt, sel_bad, err_cnt, done_cnt;
    int last_res_cyc, done_cyc;
    initial forever begin
        @(negedge clk);
        if (!i_reset) begin
            if (o_res_valid && i_res_ready) begin got_q.push_back(o_res_data); last_res_cyc = cyc; end
            if (o_frame_done) begin done_cnt++; done_cyc = cyc; end
            if (o_err) err_cnt++;
            if (o_k_ready && i_k_valid) k_xfer++;
            if (o_img_ready && i_img_valid) i_xfer++;
            if (o_selec_K) selk_cnt++;
            if (o_selec_I) seli_cnt++;
            if (o_selec_K !== (o_k_ready && i_k_valid)) sel_bad++;
            if (o_selec_I !== (o_img_ready && i_img_valid)) sel_bad++;
            if (o_data_kernel !== (o_selec_K ? i_k_data : 24'd0)) sel_bad++;
            if (o_data_img !== (o_selec_I ? i_img_data : 24'd0)) sel_bad++;
        end
    end

    int res_prob = 100;
    initial begin
        i_res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            i_res_ready = ($urandom_range(99) < res_prob);
        end
    end

    logic [23:0] kern [3];
    logic [23:0] img [16];
    int img_idx;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic reset_stats();
        got_q.delete();
        k_xfer = 0; i_xfer = 0; selk_cnt = 0; seli_cnt = 0;
        sel_bad = 0; err_cnt = 0; done_cnt = 0;
    endtask

    task automatic start_frame(input int n);
        i_start = 1'b1; i_rows = 8'(n);
        tick();
        i_start = 1'b0;
    endtask

    task automatic send_k(input int kp);
        int idx = 0;
        int guard = 0;
        logic fire;
        while (idx < 3 && guard < 2000) begin
            i_k_valid = ($urandom_range(99) < kp);
            i_k_data  = i_k_valid ? kern[idx] : 24'($urandom);
            @(negedge clk);
            fire = i_k_valid && o_k_ready;
            tick();
            if (fire) idx++;
            guard++;
        end
        i_k_valid = 1'b0; i_k_data = '0;
        check("k_rows_loaded", idx, 3);
    endtask

    task automatic send_img(input int upto, input int ip, input int maxc);
        int guard = 0;
        logic fire;
        while (img_idx < upto && guard < maxc) begin
            i_img_valid = ($urandom_range(99) < ip);
            i_img_data  = i_img_valid ? img[img_idx] : 24'($urandom);
            @(negedge clk);
            fire = i_img_valid && o_img_ready;
            tick();
            if (fire) img_idx++;
            guard++;
        end
        i_img_valid = 1'b0; i_img_data = '0;
    endtask

    task automatic wait_done();
        int guard = 0;
        logic seen = 1'b0;
        while (guard < 3000 && !seen) begin
            @(negedge clk);
            if (o_frame_done) seen = 1'b1;
            guard++;
        end
        tick();
        check("frame_done_seen", seen, 1);
    endtask

    task automatic check_results(input int n);
        logic [19:0] exp;
        check("result_count", got_q.size(), n - 2);
        for (int r = 2; r < n; r++) begin
            exp = conv9(kern[0], kern[1], kern[2], img[r-2], img[r-1], img[r]);
            if (r - 2 < got_q.size()) check("result_value", got_q[r-2], exp);
        end
        check("selec_consistency", sel_bad, 0);
        check("selK_pulses", selk_cnt, 3);
        check("selI_pulses", seli_cnt, n);
        check("no_err", err_cnt, 0);
        check("done_pulses", done_cnt, 1);
    endtask

    task automatic run_frame(input int n, input int kp, input int ip, input int rp);
        res_prob = rp;
        reset_stats();
        start_frame(n);
        send_k(kp);
        img_idx = 0;
        send_img(n, ip, 5000);
        check("img_rows_sent", img_idx, n);
        wait_done();
        check_results(n);
    endtask

    task automatic check_reset_outs(input string tag);
        @(negedge clk);
        check({tag, "_ctrl"}, {o_busy, o_err, o_k_ready, o_img_ready, o_selec_K,
                               o_selec_I, o_res_valid, o_frame_done}, 8'h00);
        check({tag, "_kdata"}, o_data_kernel, 0);
        check({tag, "_idata"}, o_data_img, 0);
        check({tag, "_rdata"}, o_res_data, 0);
        tick();
    endtask

    initial begin
        int n, done_before;
        i_reset = 1'b1; i_start = 1'b0; i_rows = '0;
        i_k_valid = 1'b0; i_k_data = '0; i_img_valid = 1'b0; i_img_data = '0;
        reset_stats();
        repeat (3) tick();
        i_reset = 1'b0;
        check_reset_outs("reset");

        // All-ones kernel and image, single result 9
        for (int j = 0; j < 3; j++) begin kern[j] = 24'h010101; img[j] = 24'h010101; end
        run_frame(3, 100, 100, 100);
        if (got_q.size() > 0) check("ones_result", got_q[0], 9);
        check("ones_done_latency", done_cyc - last_res_cyc, 1);
        $display("frame ones rows=3 results=%0d", got_q.size());

        // Identity-centre kernel, middle pixels 1..6 -> 2,3,4,5
        kern[0] = 24'h000000; kern[1] = 24'h000100; kern[2] = 24'h000000;
        for (int r = 0; r < 6; r++) img[r] = 24'((r + 1) << 8);
        run_frame(6, 100, 100, 100);
        for (int r = 0; r < 4; r++)
            if (r < got_q.size()) check("ident_result", got_q[r], 20'(r + 2));
        $display("frame identity rows=6 results=%0d", got_q.size());

        // Back-pressure: nothing consumed, credit stops the image stream
        for (int j = 0; j < 3; j++) kern[j] = 24'($urandom);
        for (int r = 0; r < 10; r++) img[r] = 24'($urandom);
        res_prob = 0;
        reset_stats();
        start_frame(10);
        send_k(100);
        img_idx = 0;
        send_img(10, 100, 30);
        check("bp_rows_accepted", img_idx, 6);
        @(negedge clk);
        check("bp_img_ready", o_img_ready, 0);
        check("bp_res_valid", o_res_valid, 1);
        check("bp_none_consumed", got_q.size(), 0);
        tick();
        res_prob = 100;
        send_img(10, 100, 500);
        check("bp_rows_sent", img_idx, 10);
        wait_done();
        check_results(10);
        $display("frame backpressure rows=10 results=%0d", got_q.size());

        // Too few rows: error pulse, no frame
        reset_stats();
        i_start = 1'b1; i_rows = 8'd2;
        @(negedge clk);
        check("short_err", o_err, 1);
        check("short_busy", o_busy, 0);
        tick();
        i_start = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("short_busy_after", o_busy, 0);
        tick();
        check("short_err_pulses", err_cnt, 1);
        check("short_selec", selk_cnt + seli_cnt, 0);
        $display("frame short rows=2 err=%0d", err_cnt);

        // Reset mid-frame after the 4th image row
        for (int r = 0; r < 8; r++) img[r] = 24'($urandom);
        res_prob = 100;
        reset_stats();
        start_frame(8);
        send_k(100);
        img_idx = 0;
        send_img(4, 100, 50);
        check("abort_rows", img_idx, 4);
        done_before = done_cnt;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check_reset_outs("abort");
        repeat (10) tick();
        check("abort_no_done", done_cnt, done_before);
        check("abort_no_err", err_cnt, 0);
        check("abort_idle", o_busy, 0);
        run_frame(8, 100, 100, 100);
        $display("frame after_abort rows=8 results=%0d", got_q.size());

        // Random throttling on all three streams
        for (int f = 0; f < 1000; f++) begin
            n = $urandom_range(3, 8);
            for (int j = 0; j < 3; j++) kern[j] = 24'($urandom);
            for (int r = 0; r < n; r++) img[r] = 24'($urandom);
            run_frame(n, $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(20, 100));
            $display("frame rand%0d rows=%0d results=%0d", f, n, got_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
